// File: rtl/dmem_pkg.sv
// Shared sizing and requester identifiers for the data-memory arbiter slice.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DEPTH  = 32;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic; the priority register always points
// at the requester that lost (or did not take) the most recent grant.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic dbg_prio
);

    req_id_e r_prio;
    req_id_e w_prio_nxt;
    logic    w_gnt0;
    logic    w_gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= REQ_CORE;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_prio_nxt = r_prio;
        if (reset_n) begin
            if (req0 && (!req1 || r_prio == REQ_CORE)) begin
                w_gnt0     = 1'b1;
                w_prio_nxt = REQ_DBG;
            end else if (req1) begin
                w_gnt1     = 1'b1;
                w_prio_nxt = REQ_CORE;
            end
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign dbg_prio = r_prio;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core LSU and the debug/DMA
// port; every accepted access gets a one-cycle-later response pulse.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              dbg_prio
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic              w_sel_we;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wd;
    logic [DATA_W-1:0] w_rsp_data;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (w_gnt0),
        .gnt1     (w_gnt1),
        .dbg_prio (dbg_prio)
    );

    always_comb begin
        w_any      = w_gnt0 | w_gnt1;
        w_sel_addr = w_gnt1 ? addr1 : addr0;
        w_sel_wd   = w_gnt1 ? wd1   : wd0;
        w_sel_we   = w_gnt1 ? we1   : we0;
        w_in_range = {1'b0, w_sel_addr} < LP_DEPTH;
        mem_we     = w_any & w_sel_we & w_in_range;
        mem_addr   = w_any ? w_sel_addr : '0;
        mem_wd     = w_any ? w_sel_wd   : '0;
        w_rsp_data = (!w_sel_we && w_in_range) ? mem_rd : '0;
    end

    // rdata only changes on a grant, so it holds its value between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            r_err0    <= w_gnt0 & ~w_in_range;
            r_err1    <= w_gnt1 & ~w_in_range;
            if (w_gnt0) begin
                r_rdata0 <= w_rsp_data;
            end
            if (w_gnt1) begin
                r_rdata1 <= w_rsp_data;
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random stimulus for dmem_arbiter against a transaction-level
// model: round-robin grant choice, a shadow memory and per-requester response queues.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DW  = DMEM_DATA_W;
    localparam int AW  = DMEM_ADDR_W;
    localparam int DEP = DMEM_DEPTH;
    localparam int IW  = $clog2(DEP);

    logic          clk;
    logic          reset_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          dbg_prio;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic          m_prio;
    logic [DW-1:0] m_rd0, m_rd1;
    logic [DW-1:0] ref_mem [DEP];
    logic [DW:0]   exp_q0 [$];
    logic [DW:0]   exp_q1 [$];

    dmem_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wd0      (wd0),
        .wd1      (wd1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .err0     (err0),
        .err1     (err1),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .dbg_prio (dbg_prio)
    );

    // ---------------- clock / reset, data memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed_word(input int i);
        return DW'(32'h1357_0000 ^ (i * 32'h0001_0203));
    endfunction

    logic [DW-1:0] tb_mem [DEP];
    assign mem_rd = (mem_addr < AW'(DEP)) ? tb_mem[mem_addr[IW-1:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEP; i++) tb_mem[i] <= seed_word(i);
        end else if (mem_we && mem_addr < AW'(DEP)) begin
            tb_mem[mem_addr[IW-1:0]] <= mem_wd;
        end
    end

    // ---------------- checkers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0,
                          input logic [DW-1:0] d0, input logic r1, input logic w1,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wd1 = d1;
    endtask

    // Checks the combinational side of the current cycle and queues the response.
    task automatic comb_check();
        logic          g0, g1, wr, inr;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rsp;
        g0  = req0 && (!req1 || m_prio == 1'b0);
        g1  = req1 && !g0;
        a   = g0 ? addr0 : (g1 ? addr1 : '0);
        d   = g0 ? wd0   : (g1 ? wd1   : '0);
        wr  = g0 ? we0   : (g1 ? we1   : 1'b0);
        inr = a < AW'(DEP);
        chk1("gnt0", gnt0, g0);
        chk1("gnt1", gnt1, g1);
        chk1("mem_we", mem_we, (g0 || g1) && wr && inr);
        chkw("mem_addr", mem_addr, a);
        chkw("mem_wd", mem_wd, d);
        if (g0 || g1) begin
            rsp = (!wr && inr) ? ref_mem[a[IW-1:0]] : '0;
            if (g0) exp_q0.push_back({!inr, rsp});
            else    exp_q1.push_back({!inr, rsp});
            if (wr && inr) ref_mem[a[IW-1:0]] = d;
            m_prio = g0;
        end
    endtask

    // Advances one edge and checks the registered response side.
    task automatic edge_check();
        logic [DW:0] e;
        @(posedge clk);
        #1;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            m_rd0 = e[DW-1:0];
            chk1("rvalid0", rvalid0, 1'b1);
            chk1("err0", err0, e[DW]);
        end else begin
            chk1("rvalid0_idle", rvalid0, 1'b0);
            chk1("err0_idle", err0, 1'b0);
        end
        chkw("rdata0", rdata0, m_rd0);
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            m_rd1 = e[DW-1:0];
            chk1("rvalid1", rvalid1, 1'b1);
            chk1("err1", err1, e[DW]);
        end else begin
            chk1("rvalid1_idle", rvalid1, 1'b0);
            chk1("err1_idle", err1, 1'b0);
        end
        chkw("rdata1", rdata1, m_rd1);
        chk1("prio", dbg_prio, m_prio);
    endtask

    task automatic cycle();
        #2;
        comb_check();
        edge_check();
    endtask

    // Asserts reset with a write request held, checks suppression and cleared state.
    task automatic do_reset();
        reset_n = 1'b0;
        set_in(1'b1, 1'b1, 32'd1, 32'h1111_1111, 1'b1, 1'b1, 32'd2, 32'h2222_2222);
        m_prio = 1'b0;
        m_rd0  = '0;
        m_rd1  = '0;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < DEP; i++) ref_mem[i] = seed_word(i);
        #1;
        chk1("rst_async_rvalid0", rvalid0, 1'b0);
        chk1("rst_async_rvalid1", rvalid1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_err0", err0, 1'b0);
        chk1("rst_err1", err1, 1'b0);
        chkw("rst_rdata0", rdata0, '0);
        chkw("rst_rdata1", rdata1, '0);
        chk1("rst_prio", dbg_prio, 1'b0);
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic          r0, w0, r1, w1;
        logic [AW-1:0] a0, a1;
        reset_n = 1'b0;
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        do_reset();

        // Write from the core, then read it back through the debug port.
        set_in(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        #2;
        chk1("w5_gnt0", gnt0, 1'b1);
        chk1("w5_mem_we", mem_we, 1'b1);
        chkw("w5_mem_addr", mem_addr, 32'd5);
        comb_check();
        edge_check();
        chk1("w5_err0", err0, 1'b0);

        set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'd5, '0);
        cycle();
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        chkw("r5_rdata1_held", rdata1, 32'hDEAD_BEEF);

        // Both requesting continuously alternates 0,1,0,1.
        do_reset();
        set_in(1'b1, 1'b0, 32'd1, '0, 1'b1, 1'b0, 32'd2, '0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk1("alt_gnt0", gnt0, (k % 2) == 0);
            comb_check();
            edge_check();
            chk1("alt_prio", dbg_prio, (k % 2) == 0);
        end

        // Out-of-range write never reaches memory and flags err.
        set_in(1'b1, 1'b1, 32'd40, 32'hCAFE_F00D, 1'b0, 1'b0, '0, '0);
        #2;
        chk1("oor_mem_we", mem_we, 1'b0);
        comb_check();
        edge_check();
        chk1("oor_err0", err0, 1'b1);
        chkw("oor_rdata0", rdata0, '0);

        // Reset right after a grant drops the pending response.
        set_in(1'b1, 1'b0, 32'd3, '0, 1'b0, 1'b0, '0, '0);
        #2;
        comb_check();
        @(posedge clk);
        do_reset();
        for (int k = 0; k < 2; k++) cycle();
        set_in(1'b1, 1'b0, 32'd4, '0, 1'b1, 1'b0, 32'd6, '0);
        #2;
        chk1("post_rst_gnt0", gnt0, 1'b1);
        comb_check();
        edge_check();

        // Random traffic, biased to a few addresses so read-after-write is common.
        for (int n = 0; n < 400; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEP, DEP + 15))
                                             : AW'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEP, DEP + 15))
                                             : AW'($urandom_range(0, 7));
            set_in(r0, w0, a0, DW'($urandom), r1, w1, a1, DW'($urandom));
            cycle();
        end
        set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning requester address width (word address).
REQ-003 SHALL have parameter DEPTH, default 32, meaning number of data-memory words.
REQ-004 SHALL have port clk, input, 1, meaning sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports req0/req1, input, 1 each, meaning access request from core LSU (0) and debug/DMA port (1).
REQ-007 SHALL have ports we0/we1, input, 1 each, meaning write (1) or read (0) for the request.
REQ-008 SHALL have ports addr0/addr1, input, ADDR_W each, meaning word address.
REQ-009 SHALL have ports wd0/wd1, input, DATA_W each, meaning write data.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each, meaning request accepted this cycle (combinational).
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 each, meaning response pulse for the requester.
REQ-012 SHALL have ports rdata0/rdata1, output, DATA_W each, meaning registered read data.
REQ-013 SHALL have ports err0/err1, output, 1 each, meaning out-of-range access flag, valid with rvalid.
REQ-014 SHALL have ports mem_we (1), mem_addr (ADDR_W), mem_wd (DATA_W), all outputs, driving the data memory.
REQ-015 SHALL have port mem_rd, input, DATA_W, meaning combinational read data from the data memory.

Function
REQ-016 SHALL accept at most one request per cycle; a transfer occurs when reqN and gntN are both high.
REQ-017 SHALL grant the only requester when one req is high, with no idle cycle.
REQ-018 SHALL, on simultaneous req0 and req1, grant the requester indicated by the priority register prio (0 selects requester 0).
REQ-019 SHALL set prio to the non-granted requester after every grant; prio SHALL hold when there is no grant.
REQ-020 SHALL drive mem_addr, mem_wd and mem_we from the granted requester in the grant cycle, with mem_we = weN & in_range.
REQ-021 SHALL drive mem_we = 0, mem_addr = 0 and mem_wd = 0 when nothing is granted.
REQ-022 SHALL define in_range as addr < DEPTH; an out-of-range write SHALL NOT reach memory.
REQ-023 SHALL pulse rvalidN for exactly one cycle, the cycle after the grant, for both reads and writes (fixed latency 1).
REQ-024 SHALL load rdataN with mem_rd sampled at the grant edge for an in-range read; for writes and out-of-range accesses, rdataN SHALL be 0.
REQ-025 SHALL assert errN with rvalidN when the granted address was out of range; otherwise errN = 0.
REQ-026 SHALL hold rdataN between responses; rvalid and err SHALL be low when there is no response.
REQ-027 SHALL alternate grants when both requesters hold req continuously: neither requester waits more than one cycle.
REQ-028 SHALL treat a read and a write to the same address in consecutive cycles as ordered: the read after the write returns the new data.

Reset
REQ-029 SHALL, while reset_n = 0, clear prio to 0, rvalid0/1 to 0, err0/1 to 0 and rdata0/1 to 0 asynchronously.
REQ-030 SHALL drop any response pending at reset assertion; none SHALL be issued after release.
REQ-031 SHALL suppress gnt0/1 and mem_we while reset_n = 0.

Structure
REQ-032 SHALL take DATA_W, ADDR_W, DEPTH and a requester-id enum (REQ_CORE = 0, REQ_DBG = 1) from shared package dmem_pkg.
REQ-033 SHALL place the grant and priority logic in one sub-module, rr_arb2; response registers SHALL stay in dmem_arbiter.

Verification
REQ-034 Reset then req0 write addr 5, wd 0xDEADBEEF -> gnt0 in the same cycle, mem_we = 1, mem_addr = 5, rvalid0 next cycle, err0 = 0.
REQ-035 req1 read addr 5 after REQ-034 -> gnt1, then rvalid1 with rdata1 = 0xDEADBEEF.
REQ-036 req0 and req1 held high for 4 cycles after reset -> grant order 0,1,0,1; prio toggles each cycle.
REQ-037 req0 write addr 40 (DEPTH 32) -> mem_we = 0, rvalid0 = 1 and err0 = 1 next cycle, rdata0 = 0.
REQ-038 reset_n asserted the cycle after a grant -> no rvalid is seen; after release prio = 0 and the first simultaneous request is granted to requester 0.
